serial_add_sub: RTL

//  Multi-cycle, digit-serial adder/subtractor. Processes DIGIT bits per clock through a

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/digit_adder.sv | 26 ++
 rtl/serial_add_sub.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic family: FSM state encodings and
// helpers for parameter legality and signed-overflow detection.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A digit size is legal when it is non-zero and evenly tiles a width of at least two bits
    function automatic bit digit_legal(input int unsigned width, input int unsigned digit);
        return (width >= 32'd2) && (digit != 32'd0) && (digit <= width) &&
               ((width % digit) == 32'd0);
    endfunction

    // Two's-complement overflow: both addend MSBs agree but the result MSB differs
    function automatic logic signed_ovf(input logic a_msb, input logic bx_msb,
                                        input logic s_msb);
        return (a_msb == bx_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice used by the serial arithmetic units.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] s_o,
    output logic             cout_o
);

    logic [DIGIT:0] c_s;

    // Ripple the carry through one full adder per bit
    always_comb begin
        c_s    = '0;
        s_o    = '0;
        c_s[0] = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
            c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c_s[DIGIT];
    end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle through one adder slice,
// with valid/ready handshakes on operands and result.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_add_sub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic             c_q,         c_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             a_msb_q,     a_msb_d;
    logic             bx_msb_q,    bx_msb_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             carry_q,     carry_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_c;
    logic [WIDTH-1:0]       b_x_s;
    logic [WIDTH+DIGIT-1:0] sum_shift_s;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a_i    (a_sh_q[DIGIT-1:0]),
        .b_i    (b_sh_q[DIGIT-1:0]),
        .cin_i  (c_q),
        .s_o    (dig_s),
        .cout_o (dig_c)
    );

    assign b_x_s       = b ^ {WIDTH{sub}};
    // New digit enters at the top; the slice drops the oldest DIGIT bits (also valid when DIGIT == WIDTH)
    assign sum_shift_s = {dig_s, sum_q};

    // Next-state logic for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        a_msb_d     = a_msb_q;
        bx_msb_d    = bx_msb_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b_x_s;
                    c_d        = sub;
                    cnt_d      = '0;
                    a_msb_d    = a[WIDTH-1];
                    bx_msb_d   = b_x_s[WIDTH-1];
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                sum_d  = sum_shift_s[WIDTH+DIGIT-1:DIGIT];
                c_d    = dig_c;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // First DONE cycle publishes the flags; afterwards hold until consumed
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    carry_d     = c_q;
                    ovf_d       = signed_ovf(a_msb_q, bx_msb_q, sum_q[WIDTH-1]);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            bx_msb_q    <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            a_msb_q     <= a_msb_d;
            bx_msb_q    <= bx_msb_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
